bloom_filter_rtl: RTL and testbench



---
 rtl/bloom_filter_pkg.sv | 13 +
 rtl/bloom_bit_array.sv | 51 +++++
 rtl/bloom_filter_rtl.sv | 103 ++++++++++
 tb/tb_bloom_filter_rtl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bloom_filter_pkg.sv
// bloom_filter_pkg
// Shared constants and types for the Bloom membership filter.
//   ADDR_W : width of a hash index (bit address into the filter array)
//   DEPTH  : number of bits in the filter array, 2^ADDR_W
//   hash_t : one hash index
package bloom_filter_pkg;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] hash_t;

endpackage

// File: rtl/bloom_bit_array.sv
// bloom_bit_array
// DEPTH-bit storage array for the Bloom filter. Two independent set ports
// can each set one bit per cycle. Two combinational read ports return the
// current (pre-edge) contents. A synchronous clear zeroes every bit.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high clear of the whole array
//   set_a      in   set bits[set_a_idx] at the clock edge
//   set_a_idx  in   index for set port A
//   set_b      in   set bits[set_b_idx] at the clock edge
//   set_b_idx  in   index for set port B
//   rd_a_idx   in   index for read port A
//   rd_b_idx   in   index for read port B
//   rd_a       out  bits[rd_a_idx], combinational
//   rd_b       out  bits[rd_b_idx], combinational
module bloom_bit_array
    import bloom_filter_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  set_a,
    input  hash_t set_a_idx,
    input  logic  set_b,
    input  hash_t set_b_idx,
    input  hash_t rd_a_idx,
    input  hash_t rd_b_idx,
    output logic  rd_a,
    output logic  rd_b
);

    logic [DEPTH-1:0] bits;

    // Equal indices on both ports simply set the same bit twice.
    always_ff @(posedge clock) begin
        if (reset) begin
            bits <= '0;
        end else begin
            if (set_a) begin
                bits[set_a_idx] <= 1'b1;
            end
            if (set_b) begin
                bits[set_b_idx] <= 1'b1;
            end
        end
    end

    assign rd_a = bits[rd_a_idx];
    assign rd_b = bits[rd_b_idx];

endmodule

// File: rtl/bloom_filter_rtl.sv
// bloom_filter_rtl
// Single-clock Bloom membership filter. An insert sets the two bits named
// by hash1/hash2; a query reports, one cycle later, whether both bits were
// already set. Queries see the array as it was before the same edge's
// insert (read-before-write). word_detected is a one-cycle pulse per query.
//
// Optional feature macro: BLOOM_FILL_COUNT_EN
//   When defined, the fill_count port exists and tracks the number of set
//   bits in the array. When undefined, the port and counter are absent.
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   enable         in   global qualifier for write and check
//   write          in   insert request (sets bits hash1 and hash2)
//   check          in   query request (tests bits hash1 and hash2)
//   hash1          in   first bit index
//   hash2          in   second bit index
//   word_detected  out  registered query result, valid the cycle after check
//   fill_count     out  number of set bits (BLOOM_FILL_COUNT_EN only)
module bloom_filter_rtl
    import bloom_filter_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              write,
    input  logic              check,
    input  hash_t             hash1,
    input  hash_t             hash2,
`ifdef BLOOM_FILL_COUNT_EN
    output logic              word_detected,
    output logic [ADDR_W:0]   fill_count
`else
    output logic              word_detected
`endif
);

    logic  wr_en;
    logic  chk_en;
    logic  rd_a;
    logic  rd_b;
    logic  detected_p1;

    assign wr_en  = enable & write;
    assign chk_en = enable & check;

    // Read ports always look at the current hash pair; they serve both the
    // query and the "was this bit already set" test for the fill counter.
    bloom_bit_array u_bit_array (
        .clock     (clock),
        .reset     (reset),
        .set_a     (wr_en),
        .set_a_idx (hash1),
        .set_b     (wr_en),
        .set_b_idx (hash2),
        .rd_a_idx  (hash1),
        .rd_b_idx  (hash2),
        .rd_a      (rd_a),
        .rd_b      (rd_b)
    );

    // ---- stage p1: registered query result ----
    // Any cycle without an enabled query drives 0, so the output pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            detected_p1 <= 1'b0;
        end else begin
            detected_p1 <= chk_en & rd_a & rd_b;
        end
    end

    assign word_detected = detected_p1;

`ifdef BLOOM_FILL_COUNT_EN
    // Number of distinct bits that an insert of (hash1, hash2) turns 0->1.
    // A repeated index only counts once.
    function automatic logic [1:0] new_bit_count(input logic a_set,
                                                 input logic b_set,
                                                 input logic same_idx);
        logic [1:0] n;
        n = {1'b0, ~a_set};
        if (!same_idx && !b_set) begin
            n = n + 2'd1;
        end
        return n;
    endfunction

    logic [1:0] new_bits;

    assign new_bits = new_bit_count(rd_a, rd_b, hash1 == hash2);

    // At most DEPTH bits can ever be set, so ADDR_W+1 bits never wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            fill_count <= '0;
        end else if (wr_en) begin
            fill_count <= fill_count + (ADDR_W+1)'(new_bits);
        end
    end
`endif

endmodule

// File: tb/tb_bloom_filter_rtl.sv
// tb_bloom_filter_rtl
// Directed self-checking bench for bloom_filter_rtl. Each step drives one
// cycle of inputs, waits for the clock edge, then samples 1 time unit later.
// fill_count checks are included only when BLOOM_FILL_COUNT_EN is defined.
module tb_bloom_filter_rtl;

    import bloom_filter_pkg::*;

    logic  clock;
    logic  reset;
    logic  enable;
    logic  write;
    logic  check;
    hash_t hash1;
    hash_t hash2;
    logic  word_detected;
`ifdef BLOOM_FILL_COUNT_EN
    logic [ADDR_W:0] fill_count;
`endif

    int vectors;
    int miscompares;

    bloom_filter_rtl dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .write         (write),
        .check         (check),
        .hash1         (hash1),
        .hash2         (hash2),
`ifdef BLOOM_FILL_COUNT_EN
        .word_detected (word_detected),
        .fill_count    (fill_count)
`else
        .word_detected (word_detected)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of inputs, let the edge happen, sample after it.
    task automatic step(input logic rst, input logic en, input logic wr,
                        input logic ck, input hash_t h1, input hash_t h2);
        reset  = rst;
        enable = en;
        write  = wr;
        check  = ck;
        hash1  = h1;
        hash2  = h2;
        @(posedge clock);
        #1;
    endtask

    task automatic expect_wd(input string tag, input logic exp);
        vectors++;
        assert (word_detected === exp) else begin
            miscompares++;
            $error("FAIL %s word_detected observed=%0b expected=%0b", tag, word_detected, exp);
        end
    endtask

`ifdef BLOOM_FILL_COUNT_EN
    task automatic expect_fill(input string tag, input int exp);
        vectors++;
        assert (fill_count === (ADDR_W+1)'(exp)) else begin
            miscompares++;
            $error("FAIL %s fill_count observed=%0d expected=%0d", tag, fill_count, exp);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset  = 1'b1;
        enable = 1'b0;
        write  = 1'b0;
        check  = 1'b0;
        hash1  = '0;
        hash2  = '0;

        // Reset with write+check active: reset wins.
        step(1, 1, 1, 1, 8'h74, 8'h61);
        expect_wd("reset_wd", 1'b0);
`ifdef BLOOM_FILL_COUNT_EN
        expect_fill("reset_fill", 0);
`endif
        step(0, 1, 0, 1, 8'h74, 8'h61);
        expect_wd("empty_check", 1'b0);

        // Insert then query the same pair.
        step(0, 1, 1, 0, 8'h74, 8'h61);
        expect_wd("after_write_idle", 1'b0);
`ifdef BLOOM_FILL_COUNT_EN
        expect_fill("fill_after_74_61", 2);
`endif
        step(0, 1, 0, 1, 8'h74, 8'h61);
        expect_wd("hit_74_61", 1'b1);
        step(0, 1, 0, 0, 8'h00, 8'h00);
        expect_wd("pulse_drops", 1'b0);

        // Second insert; false positive and misses.
        step(0, 1, 1, 0, 8'h65, 8'h64);
`ifdef BLOOM_FILL_COUNT_EN
        expect_fill("fill_after_65_64", 4);
`endif
        step(0, 1, 0, 1, 8'h74, 8'h64);
        expect_wd("false_pos_74_64", 1'b1);
        step(0, 1, 0, 1, 8'h73, 8'h20);
        expect_wd("miss_73_20", 1'b0);
        step(0, 1, 0, 1, 8'h74, 8'h20);
        expect_wd("miss_74_20", 1'b0);

        // Equal-index inserts from empty.
        step(1, 0, 0, 0, 8'h00, 8'h00);
        step(0, 1, 1, 0, 8'h74, 8'h74);
`ifdef BLOOM_FILL_COUNT_EN
        expect_fill("fill_same_idx_1", 1);
`endif
        step(0, 1, 1, 0, 8'h73, 8'h73);
`ifdef BLOOM_FILL_COUNT_EN
        expect_fill("fill_same_idx_2", 2);
`endif
        step(0, 1, 1, 1, 8'h74, 8'h73);
        expect_wd("hit_74_73", 1'b1);
`ifdef BLOOM_FILL_COUNT_EN
        expect_fill("fill_idempotent", 2);
`endif

        // Simultaneous write and check from empty: read-before-write.
        step(1, 0, 0, 0, 8'h00, 8'h00);
        step(0, 1, 1, 1, 8'h20, 8'h65);
        expect_wd("same_cycle_wr_chk", 1'b0);
        step(0, 1, 0, 1, 8'h20, 8'h65);
        expect_wd("next_cycle_chk", 1'b1);
`ifdef BLOOM_FILL_COUNT_EN
        expect_fill("fill_20_65", 2);
`endif

        // enable low: nothing is written, no query result.
        step(0, 0, 1, 1, 8'h10, 8'h11);
        expect_wd("disabled_wr_chk", 1'b0);
`ifdef BLOOM_FILL_COUNT_EN
        expect_fill("fill_frozen", 2);
`endif
        step(0, 0, 0, 1, 8'h20, 8'h65);
        expect_wd("disabled_chk_known", 1'b0);
        step(0, 1, 0, 1, 8'h10, 8'h11);
        expect_wd("miss_10_11", 1'b0);

        // Partial overlap: only one new bit.
        step(0, 1, 1, 0, 8'h10, 8'h20);
`ifdef BLOOM_FILL_COUNT_EN
        expect_fill("fill_one_new", 3);
`endif
        step(0, 1, 0, 1, 8'h10, 8'h65);
        expect_wd("hit_10_65", 1'b1);

        // Extreme indices.
        step(0, 1, 1, 0, 8'h00, 8'hFF);
`ifdef BLOOM_FILL_COUNT_EN
        expect_fill("fill_extremes", 5);
`endif
        step(0, 1, 0, 1, 8'hFF, 8'h00);
        expect_wd("hit_ff_00", 1'b1);
        step(0, 1, 0, 1, 8'h00, 8'hFE);
        expect_wd("miss_00_fe", 1'b0);

        // Reset mid-operation clears everything.
        step(1, 1, 0, 1, 8'h20, 8'h65);
        expect_wd("reset_mid_wd", 1'b0);
`ifdef BLOOM_FILL_COUNT_EN
        expect_fill("reset_mid_fill", 0);
`endif
        step(0, 1, 0, 1, 8'h20, 8'h65);
        expect_wd("post_reset_20_65", 1'b0);
        step(0, 1, 0, 1, 8'hFF, 8'h00);
        expect_wd("post_reset_ff_00", 1'b0);
        step(0, 1, 0, 1, 8'h74, 8'h73);
        expect_wd("post_reset_74_73", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
